// File: rtl/dma_add_stream.sv
// dma_add_stream
//   Streaming compute stage between the MMIO register file and the DMA engine.
//   An accepted go latches the transfer parameters and strobes read/write
//   starts to the DMA engine. Each cacheline popped from the DMA read FIFO
//   gets a 32-bit constant added to every 32-bit lane (mod 2^32) and is
//   written back in order through a 2-entry output buffer. The block reports
//   done and the number of busy cycles to MMIO.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   go                       start pulse (accepted only in IDLE or DONE)
//   rd_addr, wr_addr         source/destination cacheline addresses
//   size                     number of cachelines (0 allowed)
//   addend                   per-lane constant
//   done                     transfer complete, held until next accepted go
//   cycles                   busy cycles (START..FLUSH), saturating
//   dma_rd_go, dma_wr_go     one-cycle start strobes
//   dma_rd_addr/wr_addr/size latched transfer parameters
//   dma_empty, dma_rd_data   read FIFO status and head (first-word fall-through)
//   dma_rd_en                read FIFO pop
//   dma_full                 write path almost-full
//   dma_wr_en, dma_wr_data   write strobe and data
//   dma_rd_done, dma_wr_done engine completion flags
module dma_add_stream #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 42
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH:0]   size,
  input  logic [31:0]           addend,
  output logic                  done,
  output logic [31:0]           cycles,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [ADDR_WIDTH:0]   dma_rd_size,
  input  logic                  dma_empty,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  output logic                  dma_rd_en,
  input  logic                  dma_full,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_rd_done,
  input  logic                  dma_wr_done
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int SW    = ADDR_WIDTH + 1;
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  typedef enum logic [2:0] {IDLE, START, RUN, FLUSH, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [SW-1:0]           size_q, size_d;
  logic [SW-1:0]           in_cnt_q, in_cnt_d;
  logic [SW-1:0]           out_cnt_q, out_cnt_d;
  logic [31:0]             cycles_q, cycles_d;
  logic                    strobe_q, strobe_d;
  logic [1:0]              occ_q, occ_d;
  logic                    head_q, head_d;
  logic                    tail_q, tail_d;
  logic [31:0]             addend_q, addend_d;
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic [DATA_WIDTH-1:0]   buf_d [2];

  logic accept;
  logic pop;
  logic push;

  function automatic logic [DATA_WIDTH-1:0] add_lanes(
    input logic [DATA_WIDTH-1:0] d,
    input logic [31:0]           a
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    // Each lane wraps on its own; no carry crosses a lane boundary.
    for (int i = 0; i < LANES; i++) begin
      r[32*i +: 32] = d[32*i +: 32] + a;
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    size_d    = size_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    cycles_d  = cycles_q;
    occ_d     = occ_q;
    head_d    = head_q;
    tail_d    = tail_q;
    addend_d  = addend_q;
    buf_d     = buf_q;

    accept = go && (state_q == IDLE || state_q == DONE);
    push   = (occ_q != 2'd0) && !dma_full;
    // A full buffer can still accept a line when its head drains this cycle.
    pop    = (state_q == RUN) && !dma_empty && (in_cnt_q < size_q) &&
             (occ_q != 2'd2 || push);

    // Output buffer: tail written on pop, head advanced on push.
    if (pop) begin
      buf_d[tail_q] = add_lanes(dma_rd_data, addend_q);
      tail_d        = ~tail_q;
      in_cnt_d      = in_cnt_q + CNT_ONE;
    end
    if (push) begin
      head_d    = ~head_q;
      out_cnt_d = out_cnt_q + CNT_ONE;
    end
    case ({pop, push})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (state_q == START || state_q == RUN || state_q == FLUSH) begin
      cycles_d = sat_inc(cycles_q);
    end

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          rd_addr_d = rd_addr;
          wr_addr_d = wr_addr;
          size_d    = size;
          addend_d  = addend;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          cycles_d  = '0;
          state_d   = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (out_cnt_q == size_q) state_d = FLUSH;
      end
      FLUSH: begin
        if (dma_rd_done && dma_wr_done) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    strobe_d = (state_d == START);
  end

  // Control state: asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      size_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      cycles_q  <= '0;
      strobe_q  <= 1'b0;
      occ_q     <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      size_q    <= size_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      cycles_q  <= cycles_d;
      strobe_q  <= strobe_d;
      occ_q     <= occ_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Datapath storage: no reset; contents are only observed while occ > 0.
  always_ff @(posedge clk) begin
    addend_q <= addend_d;
    buf_q    <= buf_d;
  end

  assign done        = (state_q == DONE);
  assign cycles      = cycles_q;
  assign dma_rd_go   = strobe_q;
  assign dma_wr_go   = strobe_q;
  assign dma_rd_addr = rd_addr_q;
  assign dma_wr_addr = wr_addr_q;
  assign dma_rd_size = size_q;
  assign dma_rd_en   = pop;
  assign dma_wr_en   = push;
  // Gate the head so an empty buffer (including right after reset) shows zero.
  assign dma_wr_data = (occ_q != 2'd0) ? buf_q[head_q] : '0;

endmodule

// File: tb/tb_dma_add_stream.sv
module tb_dma_add_stream;

  localparam int DW     = 512;
  localparam int AW     = 42;
  localparam int SIZE_W = AW + 1;
  localparam int LANES  = DW / 32;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [AW-1:0]     wr_addr = '0;
  logic [SIZE_W-1:0] size = '0;
  logic [31:0]       addend = '0;
  logic              done;
  logic [31:0]       cycles;
  logic              dma_rd_go, dma_wr_go;
  logic [AW-1:0]     dma_rd_addr, dma_wr_addr;
  logic [SIZE_W-1:0] dma_rd_size;
  logic              dma_empty;
  logic [DW-1:0]     dma_rd_data;
  logic              dma_rd_en;
  logic              dma_full;
  logic              dma_wr_en;
  logic [DW-1:0]     dma_wr_data;
  logic              dma_rd_done, dma_wr_done;

  dma_add_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .size(size), .addend(addend), .done(done), .cycles(cycles),
    .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_empty(dma_empty),
    .dma_rd_data(dma_rd_data), .dma_rd_en(dma_rd_en), .dma_full(dma_full),
    .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
    .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          size;
    logic [31:0] addend;
    int          preload;
    int          pat;        // 0: lanes = line index, 1: random, 2: lanes 1/5 alternating
    int          full_pct;
    int          empty_pct;
    bit          regoo;      // pulse go again while running
    int          exp_writes;
    int          exp_left;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Environment: read FIFO, write sink and engine completion flags.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_log[$];
  int            wr_cyc[$];
  int            full_pct = 0;
  int            empty_pct = 0;
  int            viol_full = 0;
  int            viol_occ = 0;
  int            bus_cyc = 0;
  int            pop_cnt = 0;
  int            wr_cnt = 0;
  int            eng_size = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  initial begin
    logic          s_rd, s_wr, s_go;
    logic [DW-1:0] s_data;
    int            s_size;
    bit            inject;
    dma_full    = 1'b0;
    dma_empty   = 1'b1;
    dma_rd_data = '0;
    dma_rd_done = 1'b0;
    dma_wr_done = 1'b0;
    forever begin
      @(negedge clk);
      s_rd   = dma_rd_en;
      s_wr   = dma_wr_en;
      s_data = dma_wr_data;
      s_go   = dma_rd_go;
      s_size = int'(dma_rd_size);
      if (s_wr && dma_full) viol_full++;
      @(posedge clk);
      #1;
      bus_cyc++;
      if (!rst) begin
        if (s_go) begin
          pop_cnt  = 0;
          wr_cnt   = 0;
          eng_size = s_size;
        end
        if (s_rd) begin
          if (fifo_q.size() > 0) void'(fifo_q.pop_front());
          pop_cnt++;
        end
        if (s_wr) begin
          wr_log.push_back(s_data);
          wr_cyc.push_back(bus_cyc);
          wr_cnt++;
        end
        if (pop_cnt < wr_cnt || pop_cnt - wr_cnt > 2) viol_occ++;
        dma_rd_done = !s_go && (pop_cnt >= eng_size);
        dma_wr_done = !s_go && (wr_cnt >= eng_size);
      end
      dma_full    = ($urandom_range(99) < full_pct);
      inject      = ($urandom_range(99) < empty_pct);
      dma_empty   = (fifo_q.size() == 0) || inject;
      dma_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_done"},    64'(done), 64'd0);
    chk({tag, "_cycles"},  64'(cycles), 64'd0);
    chk({tag, "_rd_go"},   64'(dma_rd_go), 64'd0);
    chk({tag, "_wr_go"},   64'(dma_wr_go), 64'd0);
    chk({tag, "_rd_en"},   64'(dma_rd_en), 64'd0);
    chk({tag, "_wr_en"},   64'(dma_wr_en), 64'd0);
    chk({tag, "_wr_data"}, 64'(dma_wr_data != '0), 64'd0);
    chk({tag, "_rd_addr"}, 64'(dma_rd_addr), 64'd0);
    chk({tag, "_wr_addr"}, 64'(dma_wr_addr), 64'd0);
    chk({tag, "_rd_size"}, 64'(dma_rd_size), 64'd0);
  endtask

  task automatic start_xfer(input vec_t v);
    logic [DW-1:0] line, expl;
    logic [31:0]   val;
    fifo_q.delete();
    exp_q.delete();
    wr_log.delete();
    wr_cyc.delete();
    for (int j = 0; j < v.preload; j++) begin
      for (int i = 0; i < LANES; i++) begin
        case (v.pat)
          0:       val = 32'(j);
          2:       val = (i % 2 == 0) ? 32'd1 : 32'd5;
          default: val = $urandom;
        endcase
        line[32*i +: 32] = val;
        expl[32*i +: 32] = val + v.addend;
      end
      fifo_q.push_back(line);
      if (j < v.size) exp_q.push_back(expl);
    end
    full_pct  = v.full_pct;
    empty_pct = v.empty_pct;
    viol_full = 0;
    viol_occ  = 0;
    @(posedge clk);
    #1;
    rd_addr = AW'({$urandom, $urandom});
    wr_addr = AW'({$urandom, $urandom});
    size    = SIZE_W'(v.size);
    addend  = v.addend;
    go      = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int            n;
    logic [DW-1:0] w;
    start_xfer(v);
    @(negedge clk);
    chk({nm, "_start_rd_go"}, 64'(dma_rd_go), 64'd1);
    chk({nm, "_start_wr_go"}, 64'(dma_wr_go), 64'd1);
    chk({nm, "_start_done"},  64'(done), 64'd0);
    chk({nm, "_rd_addr"},     64'(dma_rd_addr), 64'(rd_addr));
    chk({nm, "_wr_addr"},     64'(dma_wr_addr), 64'(wr_addr));
    chk({nm, "_rd_size"},     64'(dma_rd_size), 64'(v.size));
    n = 1;
    forever begin
      @(negedge clk);
      go = 1'b0;
      if (done === 1'b1 || n >= BUDGET) break;
      n++;
      if (n == 2) chk({nm, "_strobe_once"}, 64'(dma_rd_go), 64'd0);
      if (v.regoo && n == 3) begin
        go   = 1'b1;
        size = SIZE_W'(1);
      end
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_cycles"}, 64'(cycles), 64'(n));
    chk({nm, "_cycles_min"}, 64'(cycles >= 32'd2), 64'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_done_hold"}, 64'(done), 64'd1);
    chk({nm, "_cycles_frozen"}, 64'(cycles), 64'(n));
    full_pct  = 0;
    empty_pct = 0;
    chk({nm, "_writes"}, 64'(wr_log.size()), 64'(v.exp_writes));
    for (int k = 0; k < wr_log.size() && k < exp_q.size(); k++) begin
      checks++;
      if (wr_log[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL %s_data[%0d] got=%h want=%h", nm, k, wr_log[k], exp_q[k]);
      end
    end
    chk({nm, "_no_wr_while_full"}, 64'(viol_full), 64'd0);
    chk({nm, "_occ_range"}, 64'(viol_occ), 64'd0);
    chk({nm, "_fifo_left"}, 64'(fifo_q.size()), 64'(v.exp_left));
    if (v.pat == 2 && wr_log.size() > 0) begin
      w = wr_log[0];
      chk({nm, "_wrap_lane0"}, 64'(w[31:0]), 64'd0);
      chk({nm, "_wrap_lane1"}, 64'(w[63:32]), 64'd4);
    end
    if (v.pat == 0 && v.full_pct == 0 && v.empty_pct == 0 && wr_log.size() == 4) begin
      w = wr_log[0];
      chk({nm, "_first_lane"}, 64'(w[31:0]), 64'd1);
      w = wr_log[3];
      chk({nm, "_last_lane"}, 64'(w[DW-1 -: 32]), 64'd4);
      chk({nm, "_back_to_back"}, 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
    end
  endtask

  initial begin
    vec_t vecs[6];
    vec_t vr;
    int   n;
    vecs[0] = '{4,  32'd1,          4, 0, 0,  0,  1'b0, 4,  0};
    vecs[1] = '{0,  32'd5,          0, 1, 0,  0,  1'b0, 0,  0};
    vecs[2] = '{2,  32'hFFFF_FFFF,  2, 2, 0,  0,  1'b0, 2,  0};
    vecs[3] = '{16, 32'h1234_5678, 16, 1, 50, 30, 1'b0, 16, 0};
    vecs[4] = '{4,  32'd7,          6, 1, 0,  0,  1'b0, 4,  2};
    vecs[5] = '{8,  32'd3,          8, 1, 20, 0,  1'b1, 8,  0};

    #1;
    chk_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_vec($sformatf("vec%0d", t), vecs[t]);
    end

    // Reset in the middle of an 8-line transfer, then a fresh transfer.
    vr = '{8, 32'h0000_0100, 8, 1, 0, 0, 1'b0, 8, 0};
    full_pct = 0;
    start_xfer(vr);
    full_pct = 30;
    n = 0;
    while (wr_log.size() < 3 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_writes", 64'(wr_log.size() >= 3 && wr_log.size() < 8), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    full_pct = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_vec("after_rst", vr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_add_stream.md
# dma_add_stream

Streaming compute stage between the MMIO register file and the DMA engine. On a `go` pulse it issues read and write starts to the DMA engine for `size` cachelines. Each 512-bit cacheline popped from the DMA read FIFO has a 32-bit constant added to every lane, and the result is pushed to the DMA write port in order. It reports `done` and a cycle count back to MMIO.

## Interface
Parameters:
- DATA_WIDTH, 512, cacheline width; must be a multiple of 32
- ADDR_WIDTH, 42, cacheline address width; size ports are ADDR_WIDTH+1 bits

Ports:
- Reset is `rst`, asynchronous, active-high; clock is `clk`.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- go  in  1  start pulse from MMIO; ignored unless state is IDLE or DONE
- rd_addr  in  ADDR_WIDTH  source cacheline address
- wr_addr  in  ADDR_WIDTH  destination cacheline address
- size  in  ADDR_WIDTH+1  cachelines to transfer; 0 is legal
- addend  in  32  constant added (mod 2^32) to each 32-bit lane
- done  out  1  transfer complete; held until next accepted go
- cycles  out  32  clk cycles from START through the last cycle before DONE; saturates at 2^32-1
- dma_rd_go, dma_wr_go  out  1  one-cycle start strobes to the DMA engine
- dma_rd_addr, dma_wr_addr  out  ADDR_WIDTH  latched addresses
- dma_rd_size  out  ADDR_WIDTH+1  latched size; the engine uses it for both directions
- dma_empty  in  1  read FIFO empty; dma_rd_data is valid when 0 (first-word fall-through)
- dma_rd_data  in  DATA_WIDTH  head of the read FIFO
- dma_rd_en  out  1  pop read FIFO
- dma_full  in  1  write path almost-full
- dma_wr_en  out  1  write one cacheline
- dma_wr_data  out  DATA_WIDTH  write data
- dma_rd_done, dma_wr_done  in  1  engine completion flags

## Operation
- FSM states: IDLE, START, RUN, FLUSH, DONE.
- IDLE/DONE + go:
  - latch rd_addr, wr_addr, size, addend;
  - clear in_cnt, out_cnt, cycles;
  - clear done;
  - go to START.
- START (1 cycle): dma_rd_go = dma_wr_go = 1. Go to RUN.
- RUN: pipeline active. When out_cnt == size, go to FLUSH. With size = 0 this happens on the first RUN cycle.
- FLUSH: wait for dma_rd_done && dma_wr_done, then go to DONE.
- DONE: done = 1. cycles frozen.
- Pipeline: 2-entry output buffer with occupancy `occ` in 0..2.
  - pop = RUN && !dma_empty && in_cnt < size && (occ < 2 || push).
  - push = occ > 0 && !dma_full.
  - pop writes lane-wise (dma_rd_data[32i+:32] + addend) into the buffer tail.
- dma_wr_en = push and must never be 1 while dma_full is 1. dma_wr_data = buffer head.
- Counters:
  - in_cnt increments on pop, never exceeding size;
  - out_cnt increments on push;
  - both are ADDR_WIDTH+1 bits.
- Simultaneous pop and push: occ unchanged. Data order is preserved strictly FIFO.
- dma_rd_en is forced 0 outside RUN. Extra FIFO data beyond size is never popped.
- Reset mid-transfer:
  - state goes to IDLE;
  - occ, counters, done, cycles, strobes all clear;
  - the engine is not notified.

## Timing
- Reset values: done 0, cycles 0, dma_rd_go 0, dma_wr_go 0, dma_rd_en 0, dma_wr_en 0, dma_wr_data 0. Address and size outputs are 0.
- dma_rd_go/dma_wr_go are registered and high exactly during the START cycle.
- dma_rd_en is combinational from dma_empty, occ and dma_full.
- dma_wr_en and dma_wr_data are combinational from the buffer registers and dma_full. There is no combinational path from dma_rd_data to dma_wr_data.
- Latency: a cacheline popped at edge N is available on dma_wr_data in cycle N+1. Earliest write is 1 cycle after pop.
- Throughput: 1 cacheline/cycle sustained when the FIFO is non-empty and dma_full = 0.
- `go` in START/RUN/FLUSH is ignored.
- A go arriving in DONE is accepted, and done drops on the following edge.
- cycles increments every cycle in START, RUN and FLUSH.

## Test plan
- size=4, addend=1, FIFO preloaded with lines whose lanes are 0,1,2,3 -> 4 writes, lanes 1..4, back-to-back. done rises after rd_done/wr_done. The START cycle shows dma_rd_go = dma_wr_go = 1.
- size=0 -> no rd_en/wr_en pulses. done=1 once the engine's done flags are high. cycles ≥ 2.
- addend=32'hFFFFFFFF, lane=32'h00000001 -> lane result 0 (wrap, no carry into the adjacent lane).
- size=16, dma_full toggled randomly 50% and FIFO empty injected -> exactly 16 writes, in order, with no wr_en while full, occ ≤ 2 and no dropped or duplicated line.
- FIFO holds 6 lines, size=4 -> exactly 4 pops; 2 lines remain in the FIFO.
- rst asserted in RUN after 3 of 8 writes -> all outputs at reset values immediately. A new go then completes a fresh 8-line transfer correctly.
